// File: rtl/output_uart.sv
// Byte-wide output port for a simple CPU: each OUT strobe queues one byte in a small FIFO,
// and a transmitter drains it as 8N1 serial frames on tx.
module output_uart #(
    parameter int CLKS_PER_BIT = 4,
    parameter int DEPTH        = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] bus,
    input  logic       load,
    output logic       tx,
    output logic       busy,
    output logic       full,
    output logic       overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [7:0]       TIMER_MAX = 8'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       timer_q, timer_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic             tx_q, tx_d;
    logic             overflow_q, overflow_d;
    logic             load_q, load_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       mem_q [DEPTH];
    logic [7:0]       mem_d [DEPTH];

    logic push;
    logic pop;
    logic push_ok;
    logic timer_done;

    // Transmitter: tx is computed one cycle ahead so it leaves a flop; a frame that ends
    // while bytes are still queued goes straight into the next start bit.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        tx_d       = tx_q;
        pop        = 1'b0;
        timer_done = (timer_q == TIMER_MAX);

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = mem_q[head_q];
                    timer_d = '0;
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (timer_done) begin
                    timer_d   = '0;
                    bit_idx_d = '0;
                    state_d   = DATA;
                    tx_d      = shift_q[0];
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            DATA: begin
                if (timer_done) begin
                    timer_d = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            STOP: begin
                if (timer_done) begin
                    timer_d = '0;
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        shift_d = mem_q[head_q];
                        state_d = START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // A full FIFO still accepts a push when the transmitter pops on the same edge.
    always_comb begin
        load_d     = load;
        push       = load && !load_q;
        push_ok    = push && ((count_q != DEPTH_C) || pop);
        overflow_d = overflow_q || (push && !push_ok);
        mem_d      = mem_q;
        tail_d     = tail_q;
        head_d     = head_q;
        if (push_ok) begin
            mem_d[tail_q] = bus;
            tail_d        = tail_q + PTR_W'(1);
        end
        if (pop) begin
            head_d = head_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
            load_q     <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
            load_q     <= load_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            mem_q      <= mem_d;
        end
    end

    assign tx       = tx_q;
    assign overflow = overflow_q;
    assign full     = (count_q == DEPTH_C);
    assign busy     = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_output_uart.sv
// Scoreboard bench for output_uart: accepted bytes are queued as expected frames and a
// serial receiver on tx pops and checks each decoded frame independently of the stimulus.
module tb_output_uart;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk;
    logic       reset;
    logic [7:0] bus;
    logic       load;
    logic       tx;
    logic       busy;
    logic       full;
    logic       overflow;

    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         frames_rx = 0;
    int         last_push_cyc = 0;
    logic [7:0] exp_q[$];
    int         start_cyc_q[$];

    output_uart #(
        .CLKS_PER_BIT(CPB),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .load(load),
        .tx(tx),
        .busy(busy),
        .full(full),
        .overflow(overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Called at a negedge; the push edge is the next posedge and last_push_cyc records it.
    task automatic applyStimulus(input logic [7:0] data, input int len, input bit accept);
        bus  = data;
        load = 1'b1;
        if (accept) exp_q.push_back(data);
        @(negedge clk);
        last_push_cyc = cyc;
        repeat (len - 1) @(negedge clk);
        load = 1'b0;
        @(negedge clk);
    endtask

    task automatic doReset();
        reset = 1'b1;
        load  = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic waitIdle(input int max_cycles, input string name);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, " idle before timeout"}, 32'(busy), 32'd0);
    endtask

    // Serial receiver: samples the middle of each bit and discards frames cut by reset.
    initial begin
        logic [9:0] bits;
        logic       aborted;
        logic [7:0] expd;
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && tx === 1'b0) begin
                start_cyc_q.push_back(cyc);
                aborted = 1'b0;
                bits    = '1;
                for (int k = 1; k < 10 * CPB; k++) begin
                    @(negedge clk);
                    if (reset) aborted = 1'b1;
                    if (!aborted && (k % CPB) == CPB / 2) bits[k / CPB] = tx;
                end
                if (!aborted) begin
                    frames_rx++;
                    checkOutput("rx start bit", 32'(bits[0]), 32'd0);
                    checkOutput("rx stop bit", 32'(bits[9]), 32'd1);
                    checkOutput("rx frame expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        expd = exp_q.pop_front();
                        checkOutput("rx byte", 32'(bits[8:1]), 32'(expd));
                    end
                end
            end
        end
    end

    initial begin
        int p0;
        int f0;
        int n;
        int d1;
        int d2;
        bit saw_low;

        reset = 1'b1;
        load  = 1'b0;
        bus   = 8'h00;
        repeat (3) @(negedge clk);
        checkOutput("reset tx", 32'(tx), 32'd1);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset full", 32'(full), 32'd0);
        checkOutput("reset overflow", 32'(overflow), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single byte, 3-cycle strobe.
        $display("[TB] single byte A5");
        start_cyc_q.delete();
        f0   = frames_rx;
        bus  = 8'hA5;
        load = 1'b1;
        exp_q.push_back(8'hA5);
        @(negedge clk);
        p0 = cyc;
        checkOutput("push edge tx still idle", 32'(tx), 32'd1);
        checkOutput("push edge busy", 32'(busy), 32'd1);
        @(negedge clk);
        checkOutput("latency tx low", 32'(tx), 32'd0);
        @(negedge clk);
        load = 1'b0;
        waitIdle(100, "single");
        checkOutput("single busy fall cycle", 32'(cyc - p0), 32'd41);
        checkOutput("single frame count", 32'(frames_rx - f0), 32'd1);
        checkOutput("single start cycle", 32'(start_cyc_q.size() > 0 ? start_cyc_q[0] - p0 : -1), 32'd1);

        // Back-to-back frames.
        $display("[TB] back-to-back 01 02 03");
        start_cyc_q.delete();
        f0 = frames_rx;
        applyStimulus(8'h01, 1, 1'b1);
        p0 = last_push_cyc;
        applyStimulus(8'h02, 1, 1'b1);
        applyStimulus(8'h03, 1, 1'b1);
        waitIdle(200, "b2b");
        checkOutput("b2b total cycles", 32'(cyc - p0), 32'd121);
        checkOutput("b2b frame count", 32'(frames_rx - f0), 32'd3);
        d1 = (start_cyc_q.size() >= 3) ? start_cyc_q[1] - start_cyc_q[0] : -1;
        d2 = (start_cyc_q.size() >= 3) ? start_cyc_q[2] - start_cyc_q[1] : -1;
        checkOutput("b2b gap 1", 32'(d1), 32'd40);
        checkOutput("b2b gap 2", 32'(d2), 32'd40);

        // Overflow: 10 goes straight to the shifter, 11..14 fill the FIFO, 15 is dropped.
        $display("[TB] overflow");
        for (int i = 0; i < 5; i++) applyStimulus(8'h10 + 8'(i), 1, 1'b1);
        checkOutput("full after 5th push", 32'(full), 32'd1);
        checkOutput("no overflow after 5th push", 32'(overflow), 32'd0);
        applyStimulus(8'h15, 1, 1'b0);
        checkOutput("overflow after 6th push", 32'(overflow), 32'd1);
        checkOutput("still full after drop", 32'(full), 32'd1);
        waitIdle(300, "overflow");
        checkOutput("overflow sticky", 32'(overflow), 32'd1);
        doReset();
        @(negedge clk);
        checkOutput("overflow cleared by reset", 32'(overflow), 32'd0);

        // Push on the final STOP edge while full.
        $display("[TB] simultaneous push/pop");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(8'h20 + 8'(i), 1, 1'b1);
            if (i == 0) p0 = last_push_cyc;
        end
        checkOutput("sim full before", 32'(full), 32'd1);
        n = 0;
        while (cyc != p0 + 40 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("sim reached stop edge", 32'(cyc - p0), 32'd40);
        applyStimulus(8'h25, 1, 1'b1);
        checkOutput("sim still full", 32'(full), 32'd1);
        checkOutput("sim no overflow", 32'(overflow), 32'd0);
        waitIdle(400, "simultaneous");
        checkOutput("sim overflow at end", 32'(overflow), 32'd0);

        // Reset during DATA bit 3 with two bytes queued.
        $display("[TB] reset mid-frame");
        start_cyc_q.delete();
        f0 = frames_rx;
        applyStimulus(8'h30, 1, 1'b0);
        p0 = last_push_cyc;
        applyStimulus(8'h31, 1, 1'b0);
        applyStimulus(8'h32, 1, 1'b0);
        n = 0;
        while (cyc != p0 + 18 && n < 100) begin
            @(negedge clk);
            n++;
        end
        reset = 1'b1;
        #1;
        checkOutput("midreset tx", 32'(tx), 32'd1);
        checkOutput("midreset busy", 32'(busy), 32'd0);
        checkOutput("midreset full", 32'(full), 32'd0);
        repeat (2) @(negedge clk);
        reset   = 1'b0;
        saw_low = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) saw_low = 1'b1;
        end
        checkOutput("no frame after reset", 32'(saw_low), 32'd0);
        checkOutput("midreset frames", 32'(frames_rx - f0), 32'd0);
        checkOutput("midreset starts", 32'(start_cyc_q.size()), 32'd1);
        f0 = frames_rx;
        applyStimulus(8'h33, 1, 1'b1);
        waitIdle(100, "post-reset");
        checkOutput("post-reset frame", 32'(frames_rx - f0), 32'd1);

        // Long strobe already high as reset releases.
        $display("[TB] long strobe 7F");
        f0    = frames_rx;
        reset = 1'b1;
        bus   = 8'h7F;
        load  = 1'b1;
        exp_q.push_back(8'h7F);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (i == 0) checkOutput("push at first edge after reset", 32'(busy), 32'd1);
        end
        load = 1'b0;
        @(negedge clk);
        waitIdle(100, "long");
        repeat (20) @(negedge clk);
        checkOutput("long strobe frames", 32'(frames_rx - f0), 32'd1);

        checkOutput("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
